ps2_scan_decode: RTL and testbench
==================================

PS2_SCAN_DECODE -- requirements
Module: ps2_scan_decode

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the number of clk50 cycles allowed between bytes of a multi-byte sequence (1 ms at 50 MHz).
REQ-003 Port clk50, input, 1 bit, SHALL be the system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-005 Port rx_data, input, 8 bits, SHALL carry the scan byte from the PS/2 receiver.
REQ-006 Port rx_valid, input, 1 bit, SHALL be a one-cycle strobe marking rx_data as valid.
REQ-007 Port code_ps2, output, 16 bits, SHALL hold the last make code: {8'h00, byte} for plain keys, {8'hE0, byte} for extended keys.
REQ-008 Port en, output, 1 bit, SHALL be a one-cycle strobe telling the key-code translator to sample code_ps2, ctrl, shift and ruslat.
REQ-009 Port ctrl, output, 1 bit, SHALL be high while either Ctrl key is held.
REQ-010 Port shift, output, 1 bit, SHALL be high while either Shift key is held.
REQ-011 Port ruslat, output, 1 bit, SHALL be the Russian/Latin layout flag, toggled by Caps Lock.

Function
REQ-012 The state machine SHALL have the states IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen) and PAUSE (E1 seen).
REQ-013 In IDLE, rx_valid SHALL move the machine as follows:
- E0 goes to EXT.
- F0 goes to BRK.
- E1 goes to PAUSE with a skip count of 7.
- FA, AA, EE, FE, 00 and FF are dropped and the machine stays in IDLE.
- Any other byte is a plain make.
REQ-014 In EXT, F0 SHALL go to EXTBRK; any other byte SHALL be an extended make and return to IDLE.
REQ-015 BRK and EXTBRK SHALL take the next byte as a plain or extended break and return to IDLE.
REQ-016 PAUSE SHALL discard bytes, decrement the skip count on each rx_valid, and return to IDLE after the 7th byte, without asserting en.
REQ-017 Modifier handling on make and break:
- Make 12, 59, 14 or E0 14 SHALL set the matching held flag; break SHALL clear it.
- shift SHALL equal L-shift OR R-shift; ctrl SHALL equal L-ctrl OR R-ctrl.
- Modifier codes SHALL NOT assert en or change code_ps2.
REQ-018 Extended makes and breaks of 12, 59 and 7C (fake shifts) SHALL be ignored entirely.
REQ-019 Caps Lock handling:
- Make 58 SHALL toggle ruslat only when caps_held is clear, then set caps_held.
- Break 58 SHALL clear caps_held.
- Caps Lock SHALL NOT assert en.
REQ-020 A non-modifier make completing on the rx_valid of cycle n SHALL load code_ps2 and assert en in cycle n+1 only.
REQ-021 Auto-repeated makes SHALL each produce a fresh en pulse.
REQ-022 In cycle n+1 (en high), ctrl and shift SHALL reflect the modifier state from before cycle n's byte.
REQ-023 Non-modifier breaks SHALL assert nothing and leave code_ps2 unchanged.
REQ-024 A timeout counter SHALL count while the state is not IDLE, restart on each rx_valid, and force IDLE without any output when it reaches TIMEOUT_CYCLES-1.
REQ-025 rx_valid SHALL be accepted on any cycle, including back-to-back cycles and the cycle where en is high; no byte SHALL be lost.
REQ-026 rx_valid that coincides with the timeout cycle SHALL be processed as if the machine were already in IDLE.

Reset
REQ-027 While reset is high, state SHALL be IDLE, and code_ps2, en, ctrl, shift, ruslat, the held flags, caps_held, the skip count and the timeout counter SHALL all be 0.
REQ-028 Reset SHALL abort any sequence in progress with no en pulse, and reset SHALL take priority over rx_valid.

Verification
REQ-029 Bytes 1C -> en high for exactly one cycle, one cycle after rx_valid, with code_ps2=16'h001C, shift=0, ctrl=0.
REQ-030 Bytes 12, 1C, F0 1C, F0 12 -> exactly one en, with code_ps2=001C and shift=1; shift=0 after the final byte.
REQ-031 Bytes E0 75, E0 F0 75 -> exactly one en with code_ps2=E075; bytes E0 12 -> shift stays 0 and there is no en.
REQ-032 Bytes 58, 58, F0 58, 58 -> ruslat goes 0 to 1 on the first byte, stays 1 on the repeat, and goes 1 to 0 on the final byte; no en throughout.
REQ-033 Bytes E1 14 77 E1 F0 14 F0 77, then 1C -> no en during the Pause sequence, then one en with code_ps2=001C.
REQ-034 Byte E0 followed by TIMEOUT_CYCLES idle cycles, then 1C -> code_ps2=001C (not E01C); separately, reset asserted after F0 -> next 1C produces en.

Source files
------------

// File: rtl/ps2_scan_decode.sv
// ps2_scan_decode
//   Turns the raw PS/2 set-2 scan byte stream into key events for the
//   key-code translator. It tracks the E0/F0/E1 prefixes and the Shift,
//   Ctrl and Caps Lock modifiers. For every non-modifier make it presents
//   the make code together with a one-cycle en strobe.
//
// Ports
//   clk50     system clock, rising edge
//   reset     synchronous active-high reset
//   rx_data   scan byte from the PS/2 receiver
//   rx_valid  one-cycle strobe qualifying rx_data
//   code_ps2  last make code, {8'h00,b} plain or {8'hE0,b} extended
//   en        one-cycle strobe: sample code_ps2/ctrl/shift/ruslat
//   ctrl      either Ctrl held
//   shift     either Shift held
//   ruslat    Russian/Latin layout flag, toggled by Caps Lock
module ps2_scan_decode #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] code_ps2,
    output logic        en,
    output logic        ctrl,
    output logic        shift,
    output logic        ruslat
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;

    state_t        state;
    state_t        cur;
    logic [TW-1:0] tcnt;
    logic [2:0]    skip;
    logic          lshift_held, rshift_held, lctrl_held, rctrl_held, caps_held;
    logic          timeout_hit;
    logic          key_done, key_ext, key_brk;

    // The timeout cycle itself behaves as IDLE, so a byte arriving on
    // that cycle starts a fresh sequence instead of being lost.
    assign timeout_hit = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cur = timeout_hit ? IDLE : state;
    end

    // A byte completes a key event when it is not a prefix (and, in IDLE,
    // not one of the controller status/ack bytes).
    always_comb begin
        key_done = 1'b0;
        key_ext  = 1'b0;
        key_brk  = 1'b0;
        if (rx_valid) begin
            case (cur)
                IDLE:    key_done = !(rx_data inside {8'hE0, 8'hF0, 8'hE1, 8'hFA,
                                                      8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF});
                EXT: begin
                    key_done = (rx_data != 8'hF0);
                    key_ext  = 1'b1;
                end
                BRK: begin
                    key_done = 1'b1;
                    key_brk  = 1'b1;
                end
                EXTBRK: begin
                    key_done = 1'b1;
                    key_ext  = 1'b1;
                    key_brk  = 1'b1;
                end
                default: key_done = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            skip        <= '0;
            code_ps2    <= '0;
            en          <= 1'b0;
            ruslat      <= 1'b0;
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            lctrl_held  <= 1'b0;
            rctrl_held  <= 1'b0;
            caps_held   <= 1'b0;
        end else begin
            en <= 1'b0;

            // Sequence tracking and inter-byte timeout.
            if (rx_valid) begin
                tcnt <= '0;
                case (cur)
                    IDLE: begin
                        if (rx_data == 8'hE0)      state <= EXT;
                        else if (rx_data == 8'hF0) state <= BRK;
                        else if (rx_data == 8'hE1) begin
                            state <= PAUSE;
                            skip  <= 3'd7;
                        end else                   state <= IDLE;
                    end
                    EXT:         state <= (rx_data == 8'hF0) ? EXTBRK : IDLE;
                    BRK, EXTBRK: state <= IDLE;
                    PAUSE: begin
                        skip <= skip - 3'd1;
                        if (skip <= 3'd1) state <= IDLE;
                    end
                    default:     state <= IDLE;
                endcase
            end else if (timeout_hit) begin
                state <= IDLE;
                tcnt  <= '0;
            end else if (state != IDLE) begin
                tcnt <= tcnt + 1'b1;
            end

            // Key event handling. Extended 12/59/7C are the fake shifts the
            // keyboard wraps around some keys; they carry no information.
            if (key_done) begin
                if (key_ext && (rx_data inside {8'h12, 8'h59, 8'h7C})) begin
                    // dropped
                end else if (!key_ext && rx_data == 8'h12) begin
                    lshift_held <= !key_brk;
                end else if (!key_ext && rx_data == 8'h59) begin
                    rshift_held <= !key_brk;
                end else if (!key_ext && rx_data == 8'h14) begin
                    lctrl_held  <= !key_brk;
                end else if (key_ext && rx_data == 8'h14) begin
                    rctrl_held  <= !key_brk;
                end else if (!key_ext && rx_data == 8'h58) begin
                    // Toggle once per physical press; typematic repeats
                    // arrive while caps_held is still set.
                    if (!key_brk) begin
                        if (!caps_held) ruslat <= ~ruslat;
                        caps_held <= 1'b1;
                    end else begin
                        caps_held <= 1'b0;
                    end
                end else if (!key_brk) begin
                    code_ps2 <= {(key_ext ? 8'hE0 : 8'h00), rx_data};
                    en       <= 1'b1;
                end
            end
        end
    end

    // Modifier flags only change on modifier bytes, which never raise en,
    // so on an en cycle these still show the state before the key byte.
    assign shift = lshift_held | rshift_held;
    assign ctrl  = lctrl_held  | rctrl_held;

endmodule

// File: tb/tb_ps2_scan_decode.sv
module tb_ps2_scan_decode;

    localparam int T = 40;

    logic        clk50 = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] code_ps2;
    logic        en, ctrl, shift, ruslat;

    ps2_scan_decode #(.TIMEOUT_CYCLES(T)) dut (
        .clk50(clk50), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .code_ps2(code_ps2), .en(en), .ctrl(ctrl), .shift(shift), .ruslat(ruslat)
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] code;
        logic        ctrl;
        logic        shift;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    bit          m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_caps, m_rus;
    int          m_pause, m_last;
    logic [15:0] m_code;

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_pause = 0; m_last = 0;
        m_ls = 0; m_rs = 0; m_lc = 0; m_rc = 0; m_caps = 0; m_rus = 0;
        m_code = 16'h0000;
    endfunction

    // Byte b is sampled on the edge after cycle n; any resulting en shows in cycle n+1.
    function automatic void model_byte(input logic [7:0] b, input int n);
        bit ext, brk;
        if ((m_ext || m_brk || m_pause > 0) && (n - m_last >= T)) begin
            m_ext = 0; m_brk = 0; m_pause = 0;
        end
        m_last = n;
        if (m_pause > 0) begin m_pause--; return; end
        if (!m_ext && !m_brk) begin
            if (b == 8'hE1) begin m_pause = 7; return; end
            if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) return;
            if (b == 8'hE0) begin m_ext = 1; return; end
        end
        if (b == 8'hF0 && !m_brk) begin m_brk = 1; return; end
        ext = m_ext; brk = m_brk;
        m_ext = 0; m_brk = 0;
        if (ext && (b == 8'h12 || b == 8'h59 || b == 8'h7C)) return;
        if (!ext && b == 8'h12) begin m_ls = !brk; return; end
        if (!ext && b == 8'h59) begin m_rs = !brk; return; end
        if (!ext && b == 8'h14) begin m_lc = !brk; return; end
        if (ext && b == 8'h14)  begin m_rc = !brk; return; end
        if (!ext && b == 8'h58) begin
            if (!brk) begin
                if (!m_caps) m_rus = !m_rus;
                m_caps = 1;
            end else m_caps = 0;
            return;
        end
        if (!brk) begin
            m_code = {(ext ? 8'hE0 : 8'h00), b};
            expq.push_back('{code: m_code, ctrl: m_lc | m_rc, shift: m_ls | m_rs, cyc: n + 1});
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit mon_on = 0;

    always @(negedge clk50) begin
        if (mon_on) begin
            exp_t e;
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                e = expq.pop_front();
                chk("missing_en", 32'(e.code), 32'hFFFF_FFFF);
            end
            if (en === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("unexpected_en", 32'(code_ps2), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("en_cycle", cyc, e.cyc);
                    chk("en_code", 32'(code_ps2), 32'(e.code));
                    chk("en_ctrl", 32'(ctrl), 32'(e.ctrl));
                    chk("en_shift", 32'(shift), 32'(e.shift));
                end
            end else begin
                chk("en_low", 32'(en), 32'h0);
            end
            chk("code_ps2", 32'(code_ps2), 32'(m_code));
            chk("shift", 32'(shift), 32'(m_ls | m_rs));
            chk("ctrl", 32'(ctrl), 32'(m_lc | m_rc));
            chk("ruslat", 32'(ruslat), 32'(m_rus));
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk50); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(b, cyc);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk50); #1;
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
        idle(2);
    endtask

    // A byte presented during reset must be ignored.
    task automatic do_reset();
        @(negedge clk50); #1;
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h1C;
        model_reset();
        @(negedge clk50); #1;
        rx_valid = 1'b0;
        @(negedge clk50); #1;
        reset = 1'b0;
    endtask

    logic [7:0] pool[16];

    initial begin
        pool = '{8'h1C, 8'h12, 8'h59, 8'h14, 8'h58, 8'hE0, 8'hF0, 8'hE1,
                 8'h75, 8'h7C, 8'hFA, 8'h00, 8'h23, 8'hF0, 8'hE0, 8'h1C};
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        @(negedge clk50); #1;
        mon_on = 1;
        @(negedge clk50); #1;
        reset = 1'b0;
        idle(2);

        send_seq('{8'h1C});
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
        send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
        send_seq('{8'hE0, 8'h12});
        send_seq('{8'h58, 8'h58, 8'hF0, 8'h58, 8'h58});
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});
        send(8'hE0); idle(T); send_seq('{8'h1C});
        send(8'hE0); idle(T - 1); send_seq('{8'h1C});
        send(8'hE0); idle(T - 2); send_seq('{8'h1C});
        send(8'hF0); do_reset(); send_seq('{8'h1C});
        send_seq('{8'hE0, 8'h14, 8'h2B, 8'h14, 8'h1C, 8'hE0, 8'hF0, 8'h14, 8'h1C, 8'hF0, 8'h14});

        for (int i = 0; i < 3000; i++) begin
            int g;
            if ((m_ext || m_brk || m_pause > 0) && $urandom_range(0, 19) == 0)
                g = T - 2 + int'($urandom_range(0, 2));
            else
                g = int'($urandom_range(0, 3));
            idle(g);
            if ($urandom_range(0, 399) == 0) do_reset();
            send(pool[$urandom_range(0, 15)]);
        end
        idle(4);
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
